// File: rtl/regbank_arbiter_pkg.sv
// Shared widths, op encoding and FSM state encoding for the register-bank arbiter.
package regbank_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   // ST_CLEAR is only reachable when the clear feature is built in
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WRITE     = 3'd1,
      ST_READ      = 3'd2,
      ST_READ_WAIT = 3'd3,
      ST_CLEAR     = 3'd4
   } state_t;

endpackage

// File: rtl/regbank_arbiter_rr.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arbiter_2 (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last_gnt ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/regbank_arbiter.sv
// Two-requester arbiter in front of a register bank with registered read outputs.
// Optional bank clear port pair enabled by defining REGBANK_ARB_CLEAR_EN.
//
// state        | meaning
// ST_IDLE      | arbitrate; latch winner's op/addresses/data
// ST_WRITE     | bank write strobe, ack winner
// ST_READ      | bank read strobe with latched addresses
// ST_READ_WAIT | bank outputs valid, forward as Rdata, ack winner
// ST_CLEAR     | bank clear strobe with Clear_ack (clear build only)
module regbank_arbiter
   import regbank_arbiter_pkg::*;
(
   input  logic              Clock_in,
   input  logic              Signal_reset,
   input  logic              Req_0,
   input  logic              Op_0,
   input  logic [ADDR_W-1:0] Addr_a_0,
   input  logic [ADDR_W-1:0] Addr_b_0,
   input  logic [DATA_W-1:0] Wdata_0,
   output logic              Ack_0,
   input  logic              Req_1,
   input  logic              Op_1,
   input  logic [ADDR_W-1:0] Addr_a_1,
   input  logic [ADDR_W-1:0] Addr_b_1,
   input  logic [DATA_W-1:0] Wdata_1,
   output logic              Ack_1,
   output logic [DATA_W-1:0] Rdata_1,
   output logic [DATA_W-1:0] Rdata_2,
   output logic [ADDR_W-1:0] Bank_read_1,
   output logic [ADDR_W-1:0] Bank_read_2,
   output logic [ADDR_W-1:0] Bank_waddr,
   output logic [DATA_W-1:0] Bank_wdata,
   output logic              Bank_write,
   output logic              Bank_read,
   output logic              Bank_reset,
   input  logic [DATA_W-1:0] Bank_out_1,
   input  logic [DATA_W-1:0] Bank_out_2
`ifdef REGBANK_ARB_CLEAR_EN
   ,
   input  logic              Clear_req,
   output logic              Clear_ack
`endif
);

   state_t              state_q, state_d;
   logic                last_gnt_q;
   logic                win_q;
   logic [ADDR_W-1:0]   addr_a_q, addr_b_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [1:0]          gnt;
   logic                clear_go;
   logic                sel_op;
   logic                latch;
   logic                ack_pulse;

`ifdef REGBANK_ARB_CLEAR_EN
   assign clear_go  = Clear_req;
   assign Clear_ack = (state_q == ST_CLEAR);
`else
   assign clear_go  = 1'b0;
`endif

   rr_arbiter_2 u_rr (
      .req      ({Req_1, Req_0}),
      .last_gnt (last_gnt_q),
      .gnt      (gnt)
   );

   assign sel_op = gnt[1] ? Op_1 : Op_0;
   // A pending clear wins over both requesters and leaves the pointer alone
   assign latch  = (state_q == ST_IDLE) && !clear_go && (|gnt);

   always_ff @(posedge Clock_in) begin
      if (Signal_reset) begin
         state_q    <= ST_IDLE;
         last_gnt_q <= 1'b1;
         win_q      <= 1'b0;
         addr_a_q   <= '0;
         addr_b_q   <= '0;
         wdata_q    <= '0;
      end else begin
         state_q <= state_d;
         if (latch) begin
            last_gnt_q <= gnt[1];
            win_q      <= gnt[1];
            addr_a_q   <= gnt[1] ? Addr_a_1 : Addr_a_0;
            addr_b_q   <= gnt[1] ? Addr_b_1 : Addr_b_0;
            wdata_q    <= gnt[1] ? Wdata_1  : Wdata_0;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      Bank_write = 1'b0;
      Bank_read  = 1'b0;
      ack_pulse  = 1'b0;
      Rdata_1    = '0;
      Rdata_2    = '0;
      case (state_q)
         ST_IDLE: begin
            if (clear_go) begin
               state_d = ST_CLEAR;
            end else if (|gnt) begin
               state_d = (sel_op == OP_WRITE) ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            Bank_write = 1'b1;
            ack_pulse  = 1'b1;
            state_d    = ST_IDLE;
         end
         ST_READ: begin
            Bank_read = 1'b1;
            state_d   = ST_READ_WAIT;
         end
         ST_READ_WAIT: begin
            Rdata_1   = Bank_out_1;
            Rdata_2   = Bank_out_2;
            ack_pulse = 1'b1;
            state_d   = ST_IDLE;
         end
         ST_CLEAR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign Ack_0       = ack_pulse & ~win_q;
   assign Ack_1       = ack_pulse &  win_q;
   assign Bank_read_1 = addr_a_q;
   assign Bank_read_2 = addr_b_q;
   assign Bank_waddr  = addr_a_q;
   assign Bank_wdata  = wdata_q;
   assign Bank_reset  = Signal_reset | (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed and random checks of regbank_arbiter against a transaction-level model
// with a 16x32 register bank behind it (clear tests need REGBANK_ARB_CLEAR_EN).
module tb_regbank_arbiter;

   logic        Clock_in, Signal_reset;
   logic        Req_0, Op_0, Req_1, Op_1;
   logic [3:0]  Addr_a_0, Addr_b_0, Addr_a_1, Addr_b_1;
   logic [31:0] Wdata_0, Wdata_1;
   logic        Ack_0, Ack_1;
   logic [31:0] Rdata_1, Rdata_2;
   logic [3:0]  Bank_read_1, Bank_read_2, Bank_waddr;
   logic [31:0] Bank_wdata;
   logic        Bank_write, Bank_read, Bank_reset;
   logic [31:0] Bank_out_1, Bank_out_2;
`ifdef REGBANK_ARB_CLEAR_EN
   logic        Clear_req, Clear_ack;
`endif

   regbank_arbiter dut (
      .Clock_in    (Clock_in),
      .Signal_reset(Signal_reset),
      .Req_0       (Req_0),
      .Op_0        (Op_0),
      .Addr_a_0    (Addr_a_0),
      .Addr_b_0    (Addr_b_0),
      .Wdata_0     (Wdata_0),
      .Ack_0       (Ack_0),
      .Req_1       (Req_1),
      .Op_1        (Op_1),
      .Addr_a_1    (Addr_a_1),
      .Addr_b_1    (Addr_b_1),
      .Wdata_1     (Wdata_1),
      .Ack_1       (Ack_1),
      .Rdata_1     (Rdata_1),
      .Rdata_2     (Rdata_2),
      .Bank_read_1 (Bank_read_1),
      .Bank_read_2 (Bank_read_2),
      .Bank_waddr  (Bank_waddr),
      .Bank_wdata  (Bank_wdata),
      .Bank_write  (Bank_write),
      .Bank_read   (Bank_read),
      .Bank_reset  (Bank_reset),
      .Bank_out_1  (Bank_out_1),
      .Bank_out_2  (Bank_out_2)
`ifdef REGBANK_ARB_CLEAR_EN
      ,
      .Clear_req   (Clear_req),
      .Clear_ack   (Clear_ack)
`endif
   );

   initial begin
      Clock_in = 1'b0;
      forever #5 Clock_in = ~Clock_in;
   end

   // register bank with registered read outputs
   logic [31:0] bank_mem [16];
   always @(posedge Clock_in) begin
      if (Bank_reset) begin
         for (int i = 0; i < 16; i++) bank_mem[i] <= '0;
      end else if (Bank_write) begin
         bank_mem[Bank_waddr] <= Bank_wdata;
      end
      if (Bank_read) begin
         Bank_out_1 <= bank_mem[Bank_read_1];
         Bank_out_2 <= bank_mem[Bank_read_2];
      end
   end

   int nerr = 0;
   int nchecks = 0;

   // transaction-level model state
   bit          pend [2];
   logic        p_op [2];
   logic [3:0]  p_a  [2];
   logic [3:0]  p_b  [2];
   logic [31:0] p_d  [2];
   logic [31:0] exp_mem [16];
   bit          last_gnt;
   logic [3:0]  last_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nchecks++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drive();
      Req_0 = pend[0]; Op_0 = p_op[0]; Addr_a_0 = p_a[0]; Addr_b_0 = p_b[0]; Wdata_0 = p_d[0];
      Req_1 = pend[1]; Op_1 = p_op[1]; Addr_a_1 = p_a[1]; Addr_b_1 = p_b[1]; Wdata_1 = p_d[1];
   endtask

   task automatic new_txn(input int r, input logic op, input logic [3:0] a,
                          input logic [3:0] b, input logic [31:0] d);
      pend[r] = 1'b1; p_op[r] = op; p_a[r] = a; p_b[r] = b; p_d[r] = d;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) exp_mem[i] = '0;
      last_gnt = 1'b1;
      last_a   = '0;
   endtask

   // Called at a falling edge while the arbiter idles; returns at the next idle falling edge.
   task automatic run_txn(input bit rereq);
      int          w;
      logic        op;
      logic [3:0]  a, b;
      logic [31:0] d;
      logic [1:0]  ack_exp;
      drive();
      chk("idle_ack",    32'({Ack_1, Ack_0}), 32'd0);
      chk("idle_strobe", 32'({Bank_write, Bank_read}), 32'd0);
      chk("hold_addr",   32'(Bank_waddr), 32'(last_a));
      w = (pend[0] && pend[1]) ? (last_gnt ? 0 : 1) : (pend[0] ? 0 : 1);
      last_gnt = (w == 1);
      op = p_op[w]; a = p_a[w]; b = p_b[w]; d = p_d[w];
      last_a  = a;
      ack_exp = (w == 1) ? 2'b10 : 2'b01;
      @(negedge Clock_in);
      if (op) begin
         chk("wr_ack",    32'({Ack_1, Ack_0}), 32'(ack_exp));
         chk("wr_strobe", 32'({Bank_write, Bank_read}), 32'd2);
         chk("wr_addr",   32'(Bank_waddr), 32'(a));
         chk("wr_data",   Bank_wdata, d);
         exp_mem[a] = d;
      end else begin
         chk("rd_strobe", 32'({Bank_write, Bank_read}), 32'd1);
         chk("rd_noack",  32'({Ack_1, Ack_0}), 32'd0);
         chk("rd_addr1",  32'(Bank_read_1), 32'(a));
         chk("rd_addr2",  32'(Bank_read_2), 32'(b));
         // granted requester's inputs must be ignored after the latch
         p_a[w] = 4'($urandom_range(15, 0));
         p_b[w] = 4'($urandom_range(15, 0));
         p_d[w] = $urandom;
         drive();
         @(negedge Clock_in);
         chk("rd_ack",   32'({Ack_1, Ack_0}), 32'(ack_exp));
         chk("rd_data1", Rdata_1, exp_mem[a]);
         chk("rd_data2", Rdata_2, exp_mem[b]);
      end
      if (!rereq) pend[w] = 1'b0;
      drive();
      @(negedge Clock_in);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pend[0] = 0; pend[1] = 0;
      for (int r = 0; r < 2; r++) begin
         p_op[r] = 0; p_a[r] = 0; p_b[r] = 0; p_d[r] = 0;
      end
      drive();
`ifdef REGBANK_ARB_CLEAR_EN
      Clear_req = 1'b0;
`endif
      Signal_reset = 1'b1;
      model_reset();
      repeat (3) @(negedge Clock_in);

      chk("rst_ack",    32'({Ack_1, Ack_0}), 32'd0);
      chk("rst_strobe", 32'({Bank_write, Bank_read}), 32'd0);
      chk("rst_waddr",  32'(Bank_waddr), 32'd0);
      chk("rst_wdata",  Bank_wdata, 32'd0);
      chk("rst_raddr",  32'({Bank_read_1, Bank_read_2}), 32'd0);
      chk("rst_rdata1", Rdata_1, 32'd0);
      chk("rst_rdata2", Rdata_2, 32'd0);
      chk("rst_bank_reset_hi", 32'(Bank_reset), 32'd1);
      Signal_reset = 1'b0;
      #1;
      chk("rst_bank_reset_lo", 32'(Bank_reset), 32'd0);
      @(negedge Clock_in);

      // write 0xDEADBEEF to reg 3 from requester 0
      new_txn(0, 1'b1, 4'd3, 4'd0, 32'hDEADBEEF);
      run_txn(0);

      // requester 1 reads regs 3 and 5
      new_txn(1, 1'b0, 4'd3, 4'd5, 32'h0);
      run_txn(0);

      // both held continuously: grants alternate 0,1,0,1
      new_txn(0, 1'b1, 4'd7, 4'd0, 32'h1111_0000);
      new_txn(1, 1'b1, 4'd8, 4'd0, 32'h2222_0000);
      repeat (4) run_txn(1);
      pend[0] = 0; pend[1] = 0;

      // reset while in READ: no ack, pointer returns to favour requester 0
      new_txn(0, 1'b0, 4'd7, 4'd8, 32'h0);
      drive();
      @(negedge Clock_in);
      chk("abort_in_read", 32'(Bank_read), 32'd1);
      Signal_reset = 1'b1;
      #1;
      chk("abort_bank_reset", 32'(Bank_reset), 32'd1);
      @(negedge Clock_in);
      chk("abort_noack",  32'({Ack_1, Ack_0}), 32'd0);
      chk("abort_idle",   32'({Bank_write, Bank_read}), 32'd0);
      chk("abort_waddr",  32'(Bank_waddr), 32'd0);
      Signal_reset = 1'b0;
      model_reset();
      new_txn(1, 1'b1, 4'd9, 4'd0, 32'h0BAD_F00D);
      run_txn(0);
      run_txn(0);

`ifdef REGBANK_ARB_CLEAR_EN
      new_txn(0, 1'b1, 4'd3, 4'd0, 32'hCAFE_0003);
      run_txn(0);
      new_txn(0, 1'b0, 4'd3, 4'd9, 32'h0);
      Clear_req = 1'b1;
      drive();
      @(negedge Clock_in);
      chk("clr_ack",        32'(Clear_ack), 32'd1);
      chk("clr_bank_reset", 32'(Bank_reset), 32'd1);
      chk("clr_no_req_ack", 32'({Ack_1, Ack_0}), 32'd0);
      Clear_req = 1'b0;
      for (int i = 0; i < 16; i++) exp_mem[i] = '0;
      @(negedge Clock_in);
      chk("clr_ack_done", 32'(Clear_ack), 32'd0);
      run_txn(0);
`endif

      // random traffic
      for (int it = 0; it < 60; it++) begin
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && ($urandom_range(1, 0) == 1))
               new_txn(r, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                       4'($urandom_range(15, 0)), $urandom);
         end
         if (!pend[0] && !pend[1])
            new_txn(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), $urandom);
         run_txn(0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule

// File: doc/regbank_arbiter.md
REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 SHALL have port: Clock_in  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: Signal_reset  input  1  reset, synchronous and active-high.
REQ-003 SHALL have ports, per requester i in {0,1}: Req_i  input  1  access request, held until Ack_i.
REQ-004 SHALL have: Op_i  input  1  0=read pair, 1=write.
REQ-005 SHALL have: Addr_a_i, Addr_b_i  input  4  read addresses; Addr_a_i is also the write address.
REQ-006 SHALL have: Wdata_i  input  32  write data.
REQ-007 SHALL have: Ack_i  output  1  one-cycle completion pulse.
REQ-008 SHALL have: Rdata_1, Rdata_2  output  32  read results, shared, valid only with an Ack_i for a read.
REQ-009 SHALL have bank-side ports: Bank_read_1, Bank_read_2  output  4  bank read addresses.
REQ-010 SHALL have: Bank_waddr  output  4  bank write address; Bank_wdata  output  32  bank write data.
REQ-011 SHALL have: Bank_write, Bank_read, Bank_reset  output  1  bank strobes.
REQ-012 SHALL have: Bank_out_1, Bank_out_2  input  32  registered bank outputs.

Function
REQ-013 SHALL implement the FSM IDLE, WRITE, READ, READ_WAIT.
REQ-014 IDLE: if any Req_i is high, SHALL latch the winner's Op, addresses and data, then go to WRITE (Op=1) or READ (Op=0).
REQ-015 Both Req high: SHALL grant the requester not granted last (round-robin); single Req: SHALL grant it.
REQ-016 WRITE: SHALL assert Bank_write with latched Bank_waddr/Bank_wdata and pulse Ack of the winner for one cycle, then return to IDLE.
REQ-017 READ: SHALL assert Bank_read with latched Bank_read_1/Bank_read_2, then go to READ_WAIT.
REQ-018 READ_WAIT: SHALL drive Rdata_1/Rdata_2 = Bank_out_1/Bank_out_2 and pulse Ack of the winner, then return to IDLE.
REQ-019 Latency: from Req sampled in IDLE at edge k, write Ack SHALL be high in cycle k+1; read Ack SHALL be high in cycle k+2.
REQ-020 Bank_write/Bank_read SHALL be low outside WRITE/READ; bank address/data outputs SHALL hold last latched values.
REQ-021 The last-grant pointer SHALL update only on grant; a requester holding Req after its Ack SHALL be re-arbitrated in the next IDLE cycle.
REQ-022 Req_i changes while not granted SHALL have no effect; inputs of the granted requester SHALL be ignored after the latch.
REQ-023 Ack_0 and Ack_1 SHALL never be high in the same cycle.
REQ-024 Throughput: back-to-back writes SHALL complete one per 2 cycles; reads one per 3 cycles.

Reset
REQ-025 Signal_reset high at an edge SHALL force IDLE, last-grant=1 (requester 0 wins first), all outputs 0 except Bank_reset.
REQ-026 Bank_reset SHALL equal Signal_reset combinationally (OR the clear strobe, REQ-027).
REQ-027 Reset mid-operation SHALL abort the transaction with no Ack; the requester SHALL re-request.

Configuration
REQ-028 With REGBANK_ARB_CLEAR_EN defined, SHALL add Clear_req input (1) and Clear_ack output (1). In IDLE, Clear_req SHALL take priority over both Req_i, assert Bank_reset for one cycle with Clear_ack, and leave the last-grant pointer unchanged.
REQ-029 Without REGBANK_ARB_CLEAR_EN, those ports SHALL be absent and Bank_reset SHALL equal Signal_reset only.

Structure
REQ-030 Shared package SHALL hold DATA_W=32, ADDR_W=4, the state encodings and the op encoding (OP_READ=0, OP_WRITE=1).
REQ-031 Round-robin grant SHALL be a sub-module rr_arbiter_2 (Req pair, pointer in; one-hot grant out).

Verification
REQ-032 Req_0 write, Addr_a=3, Wdata=0xDEADBEEF -> Bank_write=1, waddr=3 in k+1; Ack_0 in k+1.
REQ-033 Req_1 read, Addr_a=3, Addr_b=5 after the REQ-032 write, with bank model -> Ack_1 in k+2, Rdata_1=0xDEADBEEF, Rdata_2=0.
REQ-034 Req_0 and Req_1 held continuously after reset -> grants alternate 0,1,0,1; Ack never simultaneous.
REQ-035 Signal_reset pulsed while in READ -> no Ack; IDLE next cycle; Bank_reset=1 that cycle; requester 0 wins next.
REQ-036 REGBANK_ARB_CLEAR_EN: Clear_req with Req_0 pending -> Bank_reset plus Clear_ack first, Ack_0 afterwards; reg 3 reads 0.
